pixel_processing: RTL and testbench
===================================

Name: pixel_processing

Overview:
- LSB-substitution steganography engine, one message bit per 8-bit pixel.
- In embed mode it pops message bytes and pixel bytes from two input FIFOs and pushes stego pixels (pixel with LSB replaced) to an output FIFO.
- In extract mode it pops pixels, gathers their LSBs MSB-first and pushes each recovered 8-bit message byte to the same output FIFO.
- It sits between the pixel/message input FIFOs and the result FIFO of the steganography datapath.

Parameters:
- None. Data width is fixed at 8 bits and one bit is carried per pixel.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  0 = MODE_EMB (embed), 1 = MODE_EXT (extract); sampled only in IDLE.
- ff_pixel_data  input  8  head of the pixel FIFO (first-word-fall-through, valid while !ff_pixel_empty).
- ff_pixel_empty  input  1  pixel FIFO empty.
- ff_pixel_rd  output  1  pop strobe for the pixel FIFO.
- ff_mess_data  input  8  head of the message FIFO (first-word-fall-through).
- ff_mess_empty  input  1  message FIFO empty.
- ff_mess_rd  output  1  pop strobe for the message FIFO.
- ff_full  input  1  output FIFO full.
- ff_data  output  8  output FIFO write data.
- ff_wr  output  1  output FIFO push strobe.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- FIFO handshake:
  - Input FIFOs are show-ahead; a pop is one cycle with rd=1 while empty=0.
  - rd is never asserted while empty=1; ff_wr is never asserted while ff_full=1.
- Output timing: ff_pixel_rd, ff_mess_rd, ff_wr and ff_data are combinational from the state, the registers and the current FIFO flags/data (zero latency). ff_data = 0 whenever ff_wr = 0.
- Registers: state, msg_reg[7:0], bit_cnt[2:0], shift_reg[7:0].
- Reset (rst_n=0 at a rising edge): state=IDLE, msg_reg=0, bit_cnt=7, shift_reg=0. All outputs are 0 while in reset/IDLE without a pop.
- State IDLE:
  - mode=0 and !ff_mess_empty: assert ff_mess_rd; msg_reg<=ff_mess_data; bit_cnt<=7; go EMBED.
  - mode=0 and ff_mess_empty: stay in IDLE; no pixel is consumed.
  - mode=1: bit_cnt<=7; go EXTRACT (no pop in this cycle).
- State EMBED (per cycle):
  - If !ff_pixel_empty && !ff_full: assert ff_pixel_rd=1 and ff_wr=1 in the same cycle, with ff_data = {ff_pixel_data[7:1], msg_reg[bit_cnt]}.
  - On that cycle, if bit_cnt==0 go IDLE (next message byte is fetched there), else bit_cnt--.
  - Otherwise stall: no strobes, nothing changes.
- State EXTRACT (per cycle):
  - If !ff_pixel_empty: assert ff_pixel_rd; shift_reg <= {shift_reg[6:0], ff_pixel_data[0]}.
  - On that pop, if bit_cnt==0 go WRITE, else bit_cnt--.
  - Nothing is written to the output FIFO during EXTRACT.
- State WRITE:
  - If !ff_full: ff_wr=1, ff_data=shift_reg; go IDLE.
  - Otherwise stall.
- Bit order: MSB first in both modes. Embedding and extraction are exact inverses.
- Throughput: embed = 1 stego pixel per cycle after a 1-cycle message fetch per byte (9 cycles per byte). Extract = 8 pops + 1 write + 1 IDLE cycle per byte.
- Mode change mid-byte is ignored until the FSM returns to IDLE.
- Reset mid-operation aborts the byte; any partial data is discarded.
- Simultaneous empty and full: stall with all strobes low.

Decomposition:
- Shared package holds MODE_EMB=1'b0, MODE_EXT=1'b1, and the state encoding (IDLE, EMBED, EXTRACT, WRITE) as localparams/typedef.
- No sub-module needed; a single FSM-plus-datapath module.

Test Plan:
- Reset: rst_n=0 for 1 cycle with both input FIFOs non-empty -> all strobes 0 and ff_data=0 during reset.
- Embed: mode=0, pixels constant 232, message 0x20 -> 1 mess pop, then 8 writes 232,232,233,232,232,232,232,232, each with ff_pixel_rd=ff_wr=1, then the next message pop.
- Embed with changing pixels: 82 (bit 1) -> 83; 142 (bit 1) -> 143; 82 (bit 0) -> 82.
- Starvation: assert ff_mess_empty and ff_pixel_empty mid-run -> the current byte stalls with no strobes; once IDLE is reached with message empty, the FSM stays in IDLE with no pixel reads.
- Backpressure: ff_full=1 during EMBED -> no ff_pixel_rd and no ff_wr; deasserting resumes the exact next bit.
- Extract: mode=1, pixels 232,233,232,232,232,232,232,232 -> 8 pops, then one write ff_data=0x40; an embed-then-extract loop of 0x20 returns 0x20.

Source files
------------

// File: rtl/pixel_processing_pkg.sv
// Shared definitions for the LSB steganography engine: mode encoding and FSM states.
package pixel_processing_pkg;

  localparam logic MODE_EMB = 1'b0;
  localparam logic MODE_EXT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMBED   = 2'd1,
    EXTRACT = 2'd2,
    WRITE   = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_processing.sv
// LSB-substitution steganography engine: embeds one message bit per pixel, or
// gathers pixel LSBs MSB-first back into message bytes.
module pixel_processing
  import pixel_processing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [7:0] ff_pixel_data,
  input  logic       ff_pixel_empty,
  output logic       ff_pixel_rd,
  input  logic [7:0] ff_mess_data,
  input  logic       ff_mess_empty,
  output logic       ff_mess_rd,
  input  logic       ff_full,
  output logic [7:0] ff_data,
  output logic       ff_wr
);

  state_t     state;
  logic [7:0] msg_reg;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;

  // Strobes are zero-latency so a pop and its push land in the same cycle;
  // they are forced low while reset is held because reset only takes effect at the edge.
  always_comb begin
    ff_pixel_rd = 1'b0;
    ff_mess_rd  = 1'b0;
    ff_wr       = 1'b0;
    ff_data     = 8'd0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (mode == MODE_EMB && !ff_mess_empty) ff_mess_rd = 1'b1;
        end
        EMBED: begin
          if (!ff_pixel_empty && !ff_full) begin
            ff_pixel_rd = 1'b1;
            ff_wr       = 1'b1;
            ff_data     = {ff_pixel_data[7:1], msg_reg[bit_cnt]};
          end
        end
        EXTRACT: begin
          if (!ff_pixel_empty) ff_pixel_rd = 1'b1;
        end
        WRITE: begin
          if (!ff_full) begin
            ff_wr   = 1'b1;
            ff_data = shift_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      msg_reg   <= 8'd0;
      bit_cnt   <= 3'd7;
      shift_reg <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mode == MODE_EXT) begin
            bit_cnt <= 3'd7;
            state   <= EXTRACT;
          end else if (!ff_mess_empty) begin
            msg_reg <= ff_mess_data;
            bit_cnt <= 3'd7;
            state   <= EMBED;
          end
        end
        EMBED: begin
          if (!ff_pixel_empty && !ff_full) begin
            if (bit_cnt == 3'd0) state <= IDLE;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        EXTRACT: begin
          if (!ff_pixel_empty) begin
            shift_reg <= {shift_reg[6:0], ff_pixel_data[0]};
            if (bit_cnt == 3'd0) state <= WRITE;
            else                 bit_cnt <= bit_cnt - 3'd1;
          end
        end
        WRITE: begin
          if (!ff_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_processing.sv
// Directed self-checking bench for pixel_processing: embed, extract, stalls and reset.
module tb_pixel_processing;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [7:0] ff_pixel_data;
  logic       ff_pixel_empty;
  logic       ff_pixel_rd;
  logic [7:0] ff_mess_data;
  logic       ff_mess_empty;
  logic       ff_mess_rd;
  logic       ff_full;
  logic [7:0] ff_data;
  logic       ff_wr;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] last_data;
  logic [7:0] stego [8];
  logic [7:0] emb_a5_px  [8];
  logic [7:0] emb_a5_exp [8];
  logic [7:0] ext_px [8];

  pixel_processing dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mode           (mode),
    .ff_pixel_data  (ff_pixel_data),
    .ff_pixel_empty (ff_pixel_empty),
    .ff_pixel_rd    (ff_pixel_rd),
    .ff_mess_data   (ff_mess_data),
    .ff_mess_empty  (ff_mess_empty),
    .ff_mess_rd     (ff_mess_rd),
    .ff_full        (ff_full),
    .ff_data        (ff_data),
    .ff_wr          (ff_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic m, input logic p_empty, input logic [7:0] p_data,
                               input logic m_empty, input logic [7:0] m_data, input logic full);
    mode           = m;
    ff_pixel_empty = p_empty;
    ff_pixel_data  = p_data;
    ff_mess_empty  = m_empty;
    ff_mess_data   = m_data;
    ff_full        = full;
  endtask

  // Samples outputs mid-cycle, compares, then advances past the next rising edge.
  task automatic checkOutput(input string tag, input logic prd, input logic mrd,
                             input logic wr, input logic [7:0] data);
    @(negedge clk);
    vectors++;
    last_data = ff_data;
    assert ({ff_pixel_rd, ff_mess_rd, ff_wr, ff_data} === {prd, mrd, wr, data}) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed prd=%b mrd=%b wr=%b data=%02h, expected prd=%b mrd=%b wr=%b data=%02h",
             tag, ff_pixel_rd, ff_mess_rd, ff_wr, ff_data, prd, mrd, wr, data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    emb_a5_px  = '{8'd82, 8'd142, 8'd82, 8'd82, 8'd255, 8'd142, 8'd1, 8'd0};
    emb_a5_exp = '{8'd83, 8'd142, 8'd83, 8'd82, 8'd254, 8'd143, 8'd0, 8'd1};
    ext_px     = '{8'd232, 8'd233, 8'd232, 8'd232, 8'd232, 8'd232, 8'd232, 8'd232};

    // Reset held with both input FIFOs non-empty
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd232, 1'b0, 8'h20, 1'b0);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Embed 0x20 into constant pixels 232
    checkOutput("emb_fetch_20", 1'b0, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd232, 1'b0, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("emb_20_bit%0d", i), 1'b1, 1'b0, 1'b1, (i == 2) ? 8'd233 : 8'd232);

    // Next message byte 0xA5 with changing pixels, stalls in the middle
    checkOutput("emb_fetch_a5", 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, emb_a5_px[i], 1'b0, 8'h77, 1'b0);
      checkOutput($sformatf("emb_a5_bit%0d", i), 1'b1, 1'b0, 1'b1, emb_a5_exp[i]);
    end
    applyStimulus(1'b0, 1'b1, 8'd82, 1'b1, 8'h77, 1'b0);
    checkOutput("starve_0", 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("starve_1", 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd82, 1'b1, 8'h77, 1'b1);
    checkOutput("full_0", 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("full_1_mode_ignored", 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd82, 1'b1, 8'h77, 1'b1);
    checkOutput("empty_and_full", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 3; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, emb_a5_px[i], 1'b1, 8'h77, 1'b0);
      checkOutput($sformatf("emb_a5_bit%0d", i), 1'b1, 1'b0, 1'b1, emb_a5_exp[i]);
    end

    // IDLE with message FIFO empty: no pixel consumed
    checkOutput("idle_starve_0", 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("idle_starve_1", 1'b0, 1'b0, 1'b0, 8'd0);

    // Extract 232,233,232,... -> 0x40, with a pixel stall and a full stall
    applyStimulus(1'b1, 1'b0, 8'd232, 1'b0, 8'h77, 1'b0);
    checkOutput("ext_enter", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        applyStimulus(1'b1, 1'b1, 8'd233, 1'b0, 8'h77, 1'b0);
        checkOutput("ext_pixel_stall", 1'b0, 1'b0, 1'b0, 8'd0);
      end
      applyStimulus(1'b1, 1'b0, ext_px[i], 1'b0, 8'h77, (i == 7));
      checkOutput($sformatf("ext_pop%0d", i), 1'b1, 1'b0, 1'b0, 8'd0);
    end
    checkOutput("ext_write_full", 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd232, 1'b0, 8'h20, 1'b0);
    checkOutput("ext_write_40", 1'b0, 1'b0, 1'b1, 8'h40);

    // Round trip: embed 0x20, feed the stego pixels back through extract
    checkOutput("loop_fetch_20", 1'b0, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'd232, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("loop_emb%0d", i), 1'b1, 1'b0, 1'b1, (i == 2) ? 8'd233 : 8'd232);
      stego[i] = last_data;
    end
    applyStimulus(1'b1, 1'b0, stego[0], 1'b1, 8'h20, 1'b0);
    checkOutput("loop_ext_enter", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, stego[i], 1'b1, 8'h20, 1'b0);
      checkOutput($sformatf("loop_ext_pop%0d", i), 1'b1, 1'b0, 1'b0, 8'd0);
    end
    checkOutput("loop_write_20", 1'b0, 1'b0, 1'b1, 8'h20);

    // Reset mid-extract discards the byte and returns to IDLE
    checkOutput("rst_ext_enter", 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("rst_ext_pop0", 1'b1, 1'b0, 1'b0, 8'd0);
    checkOutput("rst_ext_pop1", 1'b1, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd232, 1'b0, 8'h55, 1'b0);
    checkOutput("rst_mid_op", 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    checkOutput("post_rst_fetch", 1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("post_rst_emb0", 1'b1, 1'b0, 1'b1, 8'd232);
    checkOutput("post_rst_emb1", 1'b1, 1'b0, 1'b1, 8'd233);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
